sink_table_writer: RTL and testbench
====================================

Name: sink_table_writer

Overview:
- Writer side of the known-sinks table. It owns the flattened NUM_ENTRIES x ID_W sink-ID vector that the sink-lookup block scans.
- Inserts new sink IDs on a valid/ready request. Before each insert it does a sequential duplicate scan, one entry per clock, matching the reader's scan order.
- New IDs go into the first free slot. When the table is full, entries are replaced round-robin.
- Sits between route-discovery logic, which produces sink IDs, and the sink-lookup / cost-evaluation blocks, which read known_sinks.

Parameters:
- NUM_ENTRIES, 10, number of table slots.
- ID_W, 5, sink/node ID width.
- CNT_W, 4, width of index/count; must hold NUM_ENTRIES.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous table flush; highest priority.
- add_valid  input  1  insert request.
- add_id  input  ID_W  ID to insert; sampled on handshake.
- add_ready  output  1  block idle, can accept a request.
- done  output  1  one-cycle completion pulse.
- dup  output  1  ID already present; valid with done.
- evicted  output  1  a valid entry was overwritten; valid with done.
- rejected  output  1  reserved ID refused; valid with done.
- known_sinks  output  NUM_ENTRIES*ID_W  entry i at bits [ID_W*i +: ID_W].
- valid_mask  output  NUM_ENTRIES  bit i = entry i holds a sink.
- count  output  CNT_W  number of valid entries, 0..NUM_ENTRIES.

Behaviour:
- Reset (async, active-high):
  - state IDLE; all valid bits 0; all ID registers all-ones (5'h1F); count 0; replace pointer 0.
  - done, dup, evicted, rejected = 0; add_ready = 1.
- Reserved ID: all-ones marks an empty slot. known_sinks always shows all-ones for invalid entries, so the reader never falsely matches an empty slot.
- States: IDLE, SCAN, WRITE, DONE.
  - add_ready = 1 only in IDLE.
  - done/dup/evicted/rejected are registered and asserted only during the DONE cycle; otherwise 0.
- Handshake: add_valid & add_ready in cycle T latches add_id.
  - If add_id == all-ones: go to DONE; done=1 and rejected=1 in T+1; no table change.
  - Otherwise: go to SCAN with idx=0.
  - While not in IDLE, add_valid is ignored and requests are not queued.
- SCAN: cycle T+1+k examines entry k.
  - If valid[k] and id[k] == latched ID: go to DONE, asserting done=1 and dup=1 in T+2+k. No change to table, count or pointer.
  - Record the lowest-index invalid slot seen during the scan.
  - At k = NUM_ENTRIES-1 with no match: go to WRITE. An empty table still scans all entries.
- WRITE: cycle T+1+NUM_ENTRIES.
  - Free slot found: write it, set its valid bit, count += 1.
  - Else (count == NUM_ENTRIES): overwrite slot at the replace pointer, set evicted; pointer advances, wrapping NUM_ENTRIES-1 -> 0.
  - New value visible on outputs from T+2+NUM_ENTRIES. DONE in that cycle with done=1, dup=0.
- DONE always returns to IDLE next cycle, so add_ready=1 again at T+3+NUM_ENTRIES (non-dup insert).
- Replace pointer moves only on eviction. A free slot is always preferred over eviction.
- count never exceeds NUM_ENTRIES and never wraps.
- clear (synchronous, any state, priority over handshake and state transitions):
  - next cycle: all valid bits 0, all IDs all-ones, count 0, pointer 0, state IDLE.
  - No done pulse for an aborted operation.
  - clear and add_valid in the same IDLE cycle: clear wins, request not accepted.
- reset mid-operation: abort immediately to reset values; no done pulse.
- Outputs are pure register outputs with no combinational path from inputs, except add_ready, which decodes state only.

Test Plan:
- Reset, then insert 3 into an empty table:
  - SCAN 10 cycles, WRITE into slot 0.
  - done=1, dup=0, evicted=0 at T+12.
  - known_sinks[4:0]=3, valid_mask=10'b1, count=1.
  - add_ready=1 at T+13.
- Insert 3, 7, 9, then 7 again:
  - second 7 matches entry 1; done=1, dup=1 at T+3.
  - count stays 3; add_ready=1 at T+4.
- Fill with IDs 0..9 (count=10), then insert 20:
  - slot 0 overwritten; evicted=1; count=10.
  - insert 21 overwrites slot 1 (pointer advanced).
  - 10 further inserts show the pointer wrapping 9 -> 0.
- Insert 31 (all-ones): done=1, rejected=1 at T+1; table unchanged.
- Assert clear during SCAN (k=4) with 5 valid entries:
  - next cycle: count=0, valid_mask=0, all known_sinks fields =5'h1F, add_ready=1.
  - no done pulse.
- Hold add_valid high continuously with changing add_id:
  - exactly one acceptance per IDLE cycle; IDs presented while busy are not latched.
  - reset asserted mid-WRITE: all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/sink_table_writer.sv
// Writer side of the known-sinks table.
// Accepts sink IDs on a valid/ready handshake. Each request first walks the table one entry
// per clock, in the same order the lookup block scans it. A request that finds its ID ends
// early as a duplicate. Otherwise the ID is written into the lowest free slot. When no slot
// is free, the slot at a round-robin replace pointer is overwritten.
// The all-ones ID marks an empty slot and cannot be inserted.
module sink_table_writer #(
  parameter int unsigned NUM_ENTRIES = 10,
  parameter int unsigned ID_W        = 5,
  parameter int unsigned CNT_W       = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        clear,
  input  logic                        add_valid,
  input  logic [ID_W-1:0]             add_id,
  output logic                        add_ready,
  output logic                        done,
  output logic                        dup,
  output logic                        evicted,
  output logic                        rejected,
  output logic [NUM_ENTRIES*ID_W-1:0] known_sinks,
  output logic [NUM_ENTRIES-1:0]      valid_mask,
  output logic [CNT_W-1:0]            count
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StScan  = 2'd1;
  localparam logic [1:0] StWrite = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  localparam logic [ID_W-1:0]  ReservedId = '1;
  localparam logic [CNT_W-1:0] LastIdx    = CNT_W'(NUM_ENTRIES - 1);
  localparam logic [CNT_W-1:0] FullCount  = CNT_W'(NUM_ENTRIES);

  // Control state
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [ID_W-1:0]  new_id_q, new_id_d;
  logic             free_found_q, free_found_d;
  logic [CNT_W-1:0] free_idx_q, free_idx_d;

  // Table state
  logic [NUM_ENTRIES*ID_W-1:0] table_q, table_d;
  logic [NUM_ENTRIES-1:0]      valid_q, valid_d;
  logic [CNT_W-1:0]            count_q, count_d;
  logic [CNT_W-1:0]            ptr_q, ptr_d;

  // Registered completion flags, high only during the DONE cycle
  logic done_q, done_d;
  logic dup_q, dup_d;
  logic evicted_q, evicted_d;
  logic rejected_q, rejected_d;

  logic [ID_W-1:0] scan_id;
  logic            scan_hit;

  // Entry under examination during the scan.
  always_comb begin
    scan_id  = table_q[ID_W*idx_q +: ID_W];
    scan_hit = valid_q[idx_q] && (scan_id == new_id_q);
  end

  // Next-state logic for control, table and completion flags.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    new_id_d     = new_id_q;
    free_found_d = free_found_q;
    free_idx_d   = free_idx_q;
    table_d      = table_q;
    valid_d      = valid_q;
    count_d      = count_q;
    ptr_d        = ptr_q;
    done_d       = 1'b0;
    dup_d        = 1'b0;
    evicted_d    = 1'b0;
    rejected_d   = 1'b0;

    case (state_q)
      StIdle: begin
        if (add_valid) begin
          new_id_d = add_id;
          if (add_id == ReservedId) begin
            // The empty-slot marker can never become a real entry.
            state_d    = StDone;
            done_d     = 1'b1;
            rejected_d = 1'b1;
          end else begin
            state_d      = StScan;
            idx_d        = '0;
            free_found_d = 1'b0;
            free_idx_d   = '0;
          end
        end
      end

      StScan: begin
        if (scan_hit) begin
          state_d = StDone;
          done_d  = 1'b1;
          dup_d   = 1'b1;
        end else begin
          // Remember only the first hole so inserts pack toward slot 0.
          if (!valid_q[idx_q] && !free_found_q) begin
            free_found_d = 1'b1;
            free_idx_d   = idx_q;
          end
          if (idx_q == LastIdx) begin
            state_d = StWrite;
          end else begin
            idx_d = idx_q + CNT_W'(1);
          end
        end
      end

      StWrite: begin
        state_d = StDone;
        done_d  = 1'b1;
        if (free_found_q) begin
          table_d[ID_W*free_idx_q +: ID_W] = new_id_q;
          valid_d[free_idx_q]              = 1'b1;
          if (count_q != FullCount) begin
            count_d = count_q + CNT_W'(1);
          end
        end else begin
          // Table full: replace round-robin; count is already at its ceiling.
          table_d[ID_W*ptr_q +: ID_W] = new_id_q;
          evicted_d                   = 1'b1;
          ptr_d                       = (ptr_q == LastIdx) ? '0 : ptr_q + CNT_W'(1);
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // Flush overrides everything, including a handshake in the same cycle.
    if (clear) begin
      state_d      = StIdle;
      idx_d        = '0;
      free_found_d = 1'b0;
      free_idx_d   = '0;
      table_d      = '1;
      valid_d      = '0;
      count_d      = '0;
      ptr_d        = '0;
      done_d       = 1'b0;
      dup_d        = 1'b0;
      evicted_d    = 1'b0;
      rejected_d   = 1'b0;
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      new_id_q     <= '0;
      free_found_q <= 1'b0;
      free_idx_q   <= '0;
      table_q      <= '1;
      valid_q      <= '0;
      count_q      <= '0;
      ptr_q        <= '0;
      done_q       <= 1'b0;
      dup_q        <= 1'b0;
      evicted_q    <= 1'b0;
      rejected_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      new_id_q     <= new_id_d;
      free_found_q <= free_found_d;
      free_idx_q   <= free_idx_d;
      table_q      <= table_d;
      valid_q      <= valid_d;
      count_q      <= count_d;
      ptr_q        <= ptr_d;
      done_q       <= done_d;
      dup_q        <= dup_d;
      evicted_q    <= evicted_d;
      rejected_q   <= rejected_d;
    end
  end

  // Invalid slots always hold the all-ones marker, so the table drives known_sinks directly.
  assign add_ready   = (state_q == StIdle);
  assign done        = done_q;
  assign dup         = dup_q;
  assign evicted     = evicted_q;
  assign rejected    = rejected_q;
  assign known_sinks = table_q;
  assign valid_mask  = valid_q;
  assign count       = count_q;

endmodule

// File: tb/tb_sink_table_writer.sv
// Scoreboard bench for sink_table_writer: the stimulus side predicts each accepted request's
// outcome, completion edge and resulting table; a negedge monitor checks the DUT against it.
module tb_sink_table_writer;
  localparam int unsigned N  = 10;
  localparam int unsigned W  = 5;
  localparam int unsigned CW = 4;

  logic             clock = 1'b0;
  logic             reset;
  logic             clear;
  logic             add_valid;
  logic [W-1:0]     add_id;
  logic             add_ready;
  logic             done;
  logic             dup;
  logic             evicted;
  logic             rejected;
  logic [N*W-1:0]   known_sinks;
  logic [N-1:0]     valid_mask;
  logic [CW-1:0]    count;

  always #5 clock = ~clock;

  sink_table_writer #(
    .NUM_ENTRIES(N),
    .ID_W       (W),
    .CNT_W      (CW)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .clear      (clear),
    .add_valid  (add_valid),
    .add_id     (add_id),
    .add_ready  (add_ready),
    .done       (done),
    .dup        (dup),
    .evicted    (evicted),
    .rejected   (rejected),
    .known_sinks(known_sinks),
    .valid_mask (valid_mask),
    .count      (count)
  );

  typedef struct {
    int             at_edge;
    logic           dup;
    logic           ev;
    logic           rej;
    logic [N*W-1:0] ks;
    logic [N-1:0]   vm;
    logic [CW-1:0]  cnt;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   chk_clear = 1'b0;

  // Reference table: plain arrays plus occupancy and replacement bookkeeping
  logic [W-1:0] m_id [N];
  logic         m_v  [N];
  int           m_ptr;
  int           m_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp_v, cyc);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_v[i]  = 1'b0;
      m_id[i] = '1;
    end
    m_ptr = 0;
    m_cnt = 0;
  endfunction

  function automatic logic [N*W-1:0] model_ks();
    logic [N*W-1:0] ks;
    for (int i = 0; i < N; i++) ks[i*W +: W] = m_v[i] ? m_id[i] : '1;
    return ks;
  endfunction

  function automatic logic [N-1:0] model_vm();
    logic [N-1:0] vm;
    for (int i = 0; i < N; i++) vm[i] = m_v[i];
    return vm;
  endfunction

  // Outcome of one accepted request, applied to the reference table immediately.
  function automatic exp_t model_insert(input logic [W-1:0] id, input int hs_edge);
    exp_t e;
    int   hit  = -1;
    int   free = -1;
    e.dup = 1'b0;
    e.ev  = 1'b0;
    e.rej = 1'b0;
    if (id == 5'h1F) begin
      e.rej     = 1'b1;
      e.at_edge = hs_edge;
    end else begin
      for (int i = 0; i < N; i++)
        if (hit < 0 && m_v[i] && m_id[i] == id) hit = i;
      if (hit >= 0) begin
        e.dup     = 1'b1;
        e.at_edge = hs_edge + 1 + hit;
      end else begin
        for (int i = 0; i < N; i++)
          if (free < 0 && !m_v[i]) free = i;
        if (free >= 0) begin
          m_id[free] = id;
          m_v[free]  = 1'b1;
          m_cnt++;
        end else begin
          m_id[m_ptr] = id;
          e.ev        = 1'b1;
          m_ptr       = (m_ptr + 1) % N;
        end
        e.at_edge = hs_edge + 1 + N;
      end
    end
    e.ks  = model_ks();
    e.vm  = model_vm();
    e.cnt = CW'(m_cnt);
    return e;
  endfunction

  // Edge sampler: records handshakes and flushes against the reference model.
  initial begin
    forever begin
      @(posedge clock);
      cyc = cyc + 1;
      if (!reset) begin
        if (clear) begin
          model_reset();
          sb.delete();
          chk_clear = 1'b1;
        end else if (add_valid && add_ready) begin
          sb.push_back(model_insert(add_id, cyc));
        end
      end
    end
  end

  // Any reset aborts the pending request and empties the table.
  initial begin
    forever begin
      @(posedge reset);
      model_reset();
      sb.delete();
      chk_clear = 1'b0;
    end
  end

  // Monitor: compares DUT outputs against the scoreboard mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (!reset) begin
        chk("add_ready", 64'(add_ready), 64'(sb.size() == 0));
        if (chk_clear) begin
          chk_clear = 1'b0;
          chk("clear_done", 64'(done), 64'(0));
          chk("clear_count", 64'(count), 64'(0));
          chk("clear_valid_mask", 64'(valid_mask), 64'(0));
          chk("clear_known_sinks", 64'(known_sinks), 64'({N*W{1'b1}}));
        end else if (done) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL spurious_done: got done=1 expected done=0 (edge %0d)", cyc);
          end else begin
            e = sb.pop_front();
            chk("done_latency", 64'(cyc), 64'(e.at_edge));
            chk("dup", 64'(dup), 64'(e.dup));
            chk("evicted", 64'(evicted), 64'(e.ev));
            chk("rejected", 64'(rejected), 64'(e.rej));
            chk("known_sinks", 64'(known_sinks), 64'(e.ks));
            chk("valid_mask", 64'(valid_mask), 64'(e.vm));
            chk("count", 64'(count), 64'(e.cnt));
          end
        end else begin
          chk("idle_flags", 64'({dup, evicted, rejected}), 64'(0));
          if (sb.size() > 0 && cyc >= sb[0].at_edge) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: got no done expected done at edge %0d (edge %0d)",
                     sb[0].at_edge, cyc);
            void'(sb.pop_front());
          end
        end
      end
    end
  end

  task automatic wait_ready();
    int budget = 0;
    @(negedge clock);
    while (!add_ready && budget < 40) begin
      @(negedge clock);
      budget++;
    end
    if (!add_ready) begin
      checks++;
      failures++;
      $display("FAIL wait_ready: got add_ready=0 expected 1 within 40 cycles");
    end
  endtask

  task automatic do_insert(input logic [W-1:0] id);
    wait_ready();
    add_valid = 1'b1;
    add_id    = id;
    @(negedge clock);
    add_valid = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
  endtask

  task automatic wait_idle();
    int budget = 0;
    while ((sb.size() != 0 || !add_ready) && budget < 40) begin
      @(negedge clock);
      budget++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL wait_idle: got %0d pending expected 0", sb.size());
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_done"}, 64'(done), 64'(0));
    chk({tag, "_flags"}, 64'({dup, evicted, rejected}), 64'(0));
    chk({tag, "_add_ready"}, 64'(add_ready), 64'(1));
    chk({tag, "_count"}, 64'(count), 64'(0));
    chk({tag, "_valid_mask"}, 64'(valid_mask), 64'(0));
    chk({tag, "_known_sinks"}, 64'(known_sinks), 64'({N*W{1'b1}}));
  endtask

  function automatic logic [W-1:0] rand_id();
    if ($urandom_range(0, 15) == 0) return 5'h1F;
    return W'($urandom_range(0, 14));
  endfunction

  // Watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    reset     = 1'b1;
    clear     = 1'b0;
    add_valid = 1'b0;
    add_id    = '0;
    repeat (2) @(negedge clock);
    check_reset_values("reset");
    reset = 1'b0;

    // Single insert into an empty table, then a duplicate on entry 1
    do_insert(5'd3);
    do_insert(5'd7);
    do_insert(5'd9);
    do_insert(5'd7);
    wait_idle();

    // Fill, evict round-robin through a full wrap, then a reserved ID
    do_clear();
    for (int i = 0; i < N; i++) do_insert(W'(i));
    do_insert(5'd20);
    do_insert(5'd21);
    for (int i = 0; i < N; i++) do_insert(W'(10 + i));
    do_insert(5'h1F);
    wait_idle();

    // Clear while scanning entry 4 with five valid entries
    do_clear();
    for (int i = 0; i < 5; i++) do_insert(W'(i + 1));
    wait_ready();
    add_valid = 1'b1;
    add_id    = 5'd20;
    @(negedge clock);
    add_valid = 1'b0;
    repeat (4) @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    wait_idle();

    // add_valid held high with a new ID every cycle
    for (int i = 0; i < 200; i++) begin
      add_valid = 1'b1;
      add_id    = rand_id();
      @(negedge clock);
    end

    // Random valid and occasional clear
    for (int i = 0; i < 400; i++) begin
      add_valid = ($urandom_range(0, 9) != 0);
      add_id    = rand_id();
      clear     = ($urandom_range(0, 49) == 0);
      @(negedge clock);
    end
    add_valid = 1'b0;
    clear     = 1'b0;
    wait_idle();

    // Asynchronous reset in the middle of the WRITE cycle
    do_insert(5'd25);
    wait_ready();
    add_valid = 1'b1;
    add_id    = 5'd26;
    @(negedge clock);
    add_valid = 1'b0;
    repeat (9) @(negedge clock);
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    check_reset_values("async_reset");
    repeat (2) @(negedge clock);
    reset = 1'b0;
    do_insert(5'd4);
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
